// File: rtl/sub4u_serial.sv
// Bit-serial unsigned subtractor: D = A - B computed LSB-first, one bit per cycle,
// with an optional re-add self-check (D + B == {borrow, A}) reported on err.
module sub4u_serial #(
    parameter int WIDTH    = 4,
    parameter int CHECK_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] d_reg;
    logic             br_reg;
    logic             err_reg;
    logic [IDX_W-1:0] bit_idx;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH:0]   sum;

    // One full-subtractor slice at bit_idx, plus the re-add used by the check.
    always_comb begin
        a_bit   = a_reg[bit_idx];
        b_bit   = b_reg[bit_idx];
        d_bit   = a_bit ^ b_bit ^ br_reg;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
        sum     = {1'b0, d_reg} + {1'b0, b_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            d_reg   <= '0;
            br_reg  <= 1'b0;
            err_reg <= 1'b0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        d_reg   <= '0;
                        br_reg  <= 1'b0;
                        err_reg <= 1'b0;
                        bit_idx <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    d_reg[bit_idx] <= d_bit;
                    br_reg         <= br_next;
                    if (bit_idx == LAST_IDX) begin
                        bit_idx <= '0;
                        state   <= (CHECK_EN != 0) ? CHECK : DONE;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                CHECK: begin
                    err_reg <= (sum != {br_reg, a_reg});
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign d         = d_reg;
    assign borrow    = br_reg;
    assign err       = (CHECK_EN != 0) ? err_reg : 1'b0;

endmodule

// File: tb/tb_sub4u_serial.sv
// Scoreboard bench for sub4u_serial: a reference model queues expected results at
// accept time; they are popped and compared when the DUT presents out_valid.
module tb_sub4u_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready, in_ready, out_valid, borrow, err;
    logic [3:0] a, b, d;
    logic       in_valid2, out_ready2, in_ready2, out_valid2, borrow2, err2;
    logic [3:0] a2, b2, d2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] d;
        logic       br;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sub4u_serial #(.WIDTH(4), .CHECK_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .borrow(borrow), .err(err)
    );

    sub4u_serial #(.WIDTH(4), .CHECK_EN(0)) dut_nochk (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .d(d2), .borrow(borrow2), .err(err2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand pair into an idle DUT and records the model result.
    task automatic accept(input logic [3:0] av, input logic [3:0] bv);
        exp_t e;
        e.d  = av - bv;
        e.br = (av < bv);
        sb.push_back(e);
        in_valid = 1'b1;
        a = av;
        b = bv;
        step();
        in_valid = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic handshake();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid, d, borrow, err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_state: got %b expected 10000000", {in_ready, out_valid, d, borrow, err});
        end
        checks++;
        if ({in_ready2, out_valid2, d2, borrow2, err2} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_state_nochk: got %b expected 10000000", {in_ready2, out_valid2, d2, borrow2, err2});
        end
    endtask

    task automatic test_vectors();
        logic [3:0] va[5] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd0};
        logic [3:0] vb[5] = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd15};
        exp_t e;
        int   cyc;
        for (int i = 0; i < 5; i++) begin
            accept(va[i], vb[i]);
            wait_out(cyc);
            checks++;
            if (cyc !== 5) begin
                errors++;
                $display("FAIL vec_latency a=%0d b=%0d: got %0d cycles expected 5", va[i], vb[i], cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vec_scoreboard: got empty queue expected one entry");
            end else begin
                e = sb.pop_front();
                checks++;
                if ({d, borrow, err} !== {e.d, e.br, 1'b0}) begin
                    errors++;
                    $display("FAIL vec_result a=%0d b=%0d: got d=%0d br=%b err=%b expected d=%0d br=%b err=0",
                             va[i], vb[i], d, borrow, err, e.d, e.br);
                end
            end
            handshake();
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                errors++;
                $display("FAIL vec_return_idle: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        int   cyc;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                repeat ($urandom_range(0, 2)) step();
                accept(4'(ai), 4'(bi));
                cyc = 0;
                while (!out_valid && cyc < 20) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL sweep_busy_ready a=%0d b=%0d: got %b expected 0", ai, bi, in_ready);
                    end
                    in_valid = 1'($urandom_range(0, 1));
                    a = 4'($urandom);
                    b = 4'($urandom);
                    step();
                    cyc++;
                end
                in_valid = 1'b0;
                checks++;
                if (cyc !== 5) begin
                    errors++;
                    $display("FAIL sweep_latency a=%0d b=%0d: got %0d expected 5", ai, bi, cyc);
                end
                repeat ($urandom_range(0, 2)) step();
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sweep_scoreboard: got empty queue expected one entry");
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if ({out_valid, d, borrow, err} !== {1'b1, e.d, e.br, 1'b0}) begin
                        errors++;
                        $display("FAIL sweep_result a=%0d b=%0d: got v=%b d=%0d br=%b err=%b expected v=1 d=%0d br=%b err=0",
                                 ai, bi, out_valid, d, borrow, err, e.d, e.br);
                    end
                end
                handshake();
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        accept(4'd7, 4'd2);
        wait_out(cyc);
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 4'($urandom);
            b = 4'($urandom);
            checks++;
            if ({in_ready, out_valid, d, borrow, err} !== {2'b01, e.d, e.br, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got %b expected %b",
                         k, {in_ready, out_valid, d, borrow, err}, {2'b01, e.d, e.br, 1'b0});
            end
            step();
        end
        handshake();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL stall_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_result: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   cyc;
        accept(4'd9, 4'd3);
        step();
        rst_n = 1'b0;
        #1;
        e = sb.pop_back();
        checks++;
        if ({in_ready, out_valid, d, borrow, err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL midreset_state: got %b expected 10000000", {in_ready, out_valid, d, borrow, err});
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_output: got valid=%b expected 0", out_valid);
        end
        rst_n = 1'b1;
        step();
        accept(4'd12, 4'd5);
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if ({cyc[3:0], d, borrow, err} !== {4'd5, e.d, e.br, 1'b0} || e.d !== 4'd7) begin
            errors++;
            $display("FAIL midreset_next: got lat=%0d d=%0d br=%b err=%b expected lat=5 d=7 br=0 err=0",
                     cyc, d, borrow, err);
        end
        handshake();
    endtask

    task automatic test_force_err();
        exp_t e;
        accept(4'd9, 4'd3);
        e = sb.pop_back();
        repeat (4) step();
        force dut.d_reg = 4'b0100;
        step();
        release dut.d_reg;
        checks++;
        if ({out_valid, err} !== 2'b11) begin
            errors++;
            $display("FAIL force_err: got valid=%b err=%b expected valid=1 err=1", out_valid, err);
        end
        handshake();
    endtask

    task automatic test_nocheck();
        int cyc;
        in_valid2 = 1'b1;
        a2 = 4'd9;
        b2 = 4'd3;
        step();
        in_valid2 = 1'b0;
        cyc = 0;
        while (!out_valid2 && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL nochk_latency: got %0d expected 4", cyc);
        end
        checks++;
        if ({d2, borrow2, err2} !== {4'd6, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL nochk_result: got d=%0d br=%b err=%b expected d=6 br=0 err=0", d2, borrow2, err2);
        end
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        checks++;
        if ({in_ready2, out_valid2} !== 2'b10) begin
            errors++;
            $display("FAIL nochk_return_idle: got ready=%b valid=%b expected ready=1 valid=0", in_ready2, out_valid2);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_force_err();
        test_nocheck();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
